// File: rtl/lcd_spi_tx.sv
// Write-only SPI transmitter for a 9-bit LCD word (D/C flag + 8-bit payload), SPI mode 0, MSB first.
// One word per en_write accept; sclk half-period is CLK_DIV system clocks.
module lcd_spi_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk_50MHz,
    input  logic       rst,
    input  logic [8:0] data,
    input  logic       en_write,
    output logic       sclk,
    output logic       mosi,
    output logic       cs,
    output logic       dc,
    output logic       wr_done,
    output logic       busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

    logic [1:0] state_reg;
    logic [8:0] shift_reg;
    logic [7:0] div_cnt_reg;
    logic [2:0] bit_cnt_reg;
    logic       sclk_reg;
    logic       mosi_reg;
    logic       cs_reg;
    logic       dc_reg;
    logic       wr_done_reg;
    logic       busy_reg;

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= 9'd0;
            div_cnt_reg <= 8'd0;
            bit_cnt_reg <= 3'd0;
            sclk_reg    <= 1'b0;
            mosi_reg    <= 1'b0;
            cs_reg      <= 1'b1;
            dc_reg      <= 1'b0;
            wr_done_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            wr_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    sclk_reg <= 1'b0;
                    if (en_write) begin
                        shift_reg   <= data;
                        cs_reg      <= 1'b0;
                        dc_reg      <= data[8];
                        mosi_reg    <= data[7];
                        bit_cnt_reg <= 3'd7;
                        div_cnt_reg <= 8'd0;
                        busy_reg    <= 1'b1;
                        state_reg   <= SHIFT;
                    end else begin
                        cs_reg <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt_reg == DIV_TC) begin
                        div_cnt_reg <= 8'd0;
                        if (!sclk_reg) begin
                            // Rising edge: the LCD samples mosi, so it must not move here.
                            sclk_reg <= 1'b1;
                        end else if (bit_cnt_reg != 3'd0) begin
                            sclk_reg    <= 1'b0;
                            bit_cnt_reg <= bit_cnt_reg - 3'd1;
                            shift_reg   <= {shift_reg[8], shift_reg[6:0], 1'b0};
                            mosi_reg    <= shift_reg[6];
                        end else begin
                            sclk_reg    <= 1'b0;
                            cs_reg      <= 1'b1;
                            wr_done_reg <= 1'b1;
                            state_reg   <= DONE;
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 8'd1;
                    end
                end
                DONE: begin
                    // en_write is deliberately ignored here so upstream gets a cycle to update data.
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    cs_reg    <= 1'b1;
                    sclk_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign sclk    = sclk_reg;
    assign mosi    = mosi_reg;
    assign cs      = cs_reg;
    assign dc      = dc_reg;
    assign wr_done = wr_done_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Directed bench for lcd_spi_tx: one instance at CLK_DIV=2 (a) and one at CLK_DIV=1 (b).
// Table-driven single words plus streaming, mid-word disturbance and mid-word reset sequences.
module tb_lcd_spi_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] data_a, data_b;
    logic       en_a, en_b;
    logic       sclk_a, mosi_a, cs_a, dc_a, wr_done_a, busy_a;
    logic       sclk_b, mosi_b, cs_b, dc_b, wr_done_b, busy_b;
    logic       sel;
    logic       m_sclk, m_mosi, m_cs, m_dc, m_wr_done, m_busy;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    lcd_spi_tx #(.CLK_DIV(2)) dut_a (
        .clk_50MHz(clk), .rst(rst), .data(data_a), .en_write(en_a),
        .sclk(sclk_a), .mosi(mosi_a), .cs(cs_a), .dc(dc_a), .wr_done(wr_done_a), .busy(busy_a)
    );

    lcd_spi_tx #(.CLK_DIV(1)) dut_b (
        .clk_50MHz(clk), .rst(rst), .data(data_b), .en_write(en_b),
        .sclk(sclk_b), .mosi(mosi_b), .cs(cs_b), .dc(dc_b), .wr_done(wr_done_b), .busy(busy_b)
    );

    assign m_sclk    = sel ? sclk_b    : sclk_a;
    assign m_mosi    = sel ? mosi_b    : mosi_a;
    assign m_cs      = sel ? cs_b      : cs_a;
    assign m_dc      = sel ? dc_b      : dc_a;
    assign m_wr_done = sel ? wr_done_b : wr_done_a;
    assign m_busy    = sel ? busy_b    : busy_a;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Send one word on the selected DUT with a one-cycle en_write pulse and observe it to wr_done.
    task automatic do_word(input logic s, input logic [8:0] d, output logic [7:0] cap,
                           output int lat, output int cs_low, output int rises,
                           output int dc_bad, output int mosi_bad);
        logic prev_sclk, prev_mosi;
        int   cyc;
        sel = s;
        @(negedge clk);
        if (s) begin data_b = d; en_b = 1'b1; end
        else   begin data_a = d; en_a = 1'b1; end
        @(posedge clk); #1;
        if (s) en_b = 1'b0; else en_a = 1'b0;
        cap = 8'd0; lat = -1; cs_low = 0; rises = 0; dc_bad = 0; mosi_bad = 0; cyc = 0;
        if (!m_cs) cs_low++;
        if (m_dc !== d[8]) dc_bad++;
        prev_sclk = m_sclk;
        prev_mosi = m_mosi;
        while (cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
            if (!m_cs) cs_low++;
            if (!m_cs && m_dc !== d[8]) dc_bad++;
            if (!prev_sclk && m_sclk) begin
                rises++;
                cap = {cap[6:0], m_mosi};
            end
            if (m_mosi !== prev_mosi && !(prev_sclk && !m_sclk)) mosi_bad++;
            prev_sclk = m_sclk;
            prev_mosi = m_mosi;
            if (m_wr_done) begin
                lat = cyc;
                break;
            end
        end
    endtask

    typedef struct {
        logic       s;
        logic [8:0] d;
        logic [7:0] exp_byte;
        int         exp_lat;
    } vec_t;

    vec_t       vecs[6];
    logic [8:0] seq[3];

    initial begin
        logic [7:0] cap;
        int lat, cs_low, rises, dc_bad, mosi_bad;
        int cyc, w, last_acc, gap, extra, act_bad, wd_seen;
        logic pending, prev_cs, prev_sclk;

        vecs[0] = '{1'b0, 9'h1F8, 8'hF8, 32};
        vecs[1] = '{1'b0, 9'h036, 8'h36, 32};
        vecs[2] = '{1'b1, 9'h1A5, 8'hA5, 16};
        vecs[3] = '{1'b1, 9'h0C3, 8'hC3, 16};
        vecs[4] = '{1'b0, 9'h100, 8'h00, 32};
        vecs[5] = '{1'b1, 9'h0FF, 8'hFF, 16};
        seq[0] = 9'h107; seq[1] = 9'h1E0; seq[2] = 9'h107;

        sel = 1'b0; rst = 1'b1; en_a = 1'b1; en_b = 1'b1; data_a = 9'h1FF; data_b = 9'h1FF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_a", int'(cs_a), 1);
        check("rst_sclk_a", int'(sclk_a), 0);
        check("rst_mosi_a", int'(mosi_a), 0);
        check("rst_dc_a", int'(dc_a), 0);
        check("rst_wr_done_a", int'(wr_done_a), 0);
        check("rst_busy_a", int'(busy_a), 0);
        check("rst_cs_b", int'(cs_b), 1);
        check("rst_busy_b", int'(busy_b), 0);
        en_a = 1'b0; en_b = 1'b0; data_a = 9'd0; data_b = 9'd0;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            do_word(vecs[i].s, vecs[i].d, cap, lat, cs_low, rises, dc_bad, mosi_bad);
            check($sformatf("vec%0d_byte", i), int'(cap), int'(vecs[i].exp_byte));
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_cs_low", i), cs_low, vecs[i].exp_lat);
            check($sformatf("vec%0d_rises", i), rises, 8);
            check($sformatf("vec%0d_dc_bad", i), dc_bad, 0);
            check($sformatf("vec%0d_mosi_bad", i), mosi_bad, 0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_wr_done_pulse", i), int'(m_wr_done), 0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_busy_after", i), int'(m_busy), 0);
            check($sformatf("vec%0d_dc_hold", i), int'(m_dc), int'(vecs[i].d[8]));
            $display("word %0d: data=%h byte=%h lat=%0d cs_low=%0d rises=%0d", i, vecs[i].d, cap, lat, cs_low, rises);
        end

        // Streaming with en_write held; a junk value is presented in the DONE cycle.
        sel = 1'b0;
        @(negedge clk);
        data_a = seq[0]; en_a = 1'b1;
        w = 0; pending = 1'b0; last_acc = -1; gap = 0; prev_cs = 1'b1; prev_sclk = 1'b0;
        cap = 8'd0; cyc = 0;
        while (w < 3 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (pending) begin
                data_a = seq[w];
                pending = 1'b0;
            end
            if (prev_cs && !cs_a) begin
                if (last_acc >= 0) begin
                    check("stream_spacing", cyc - last_acc, 34);
                    check("stream_cs_gap", gap, 2);
                end
                last_acc = cyc;
                gap = 0;
            end else if (cs_a) begin
                gap++;
            end
            if (!prev_sclk && sclk_a) cap = {cap[6:0], mosi_a};
            if (wr_done_a) begin
                check("stream_byte", int'(cap), int'(seq[w][7:0]));
                $display("stream word %0d: byte=%h cycle=%0d", w, cap, cyc);
                w++;
                cap = 8'd0;
                data_a = 9'h0AA;
                pending = 1'b1;
                if (w == 3) en_a = 1'b0;
            end
            prev_cs = cs_a;
            prev_sclk = sclk_a;
        end
        check("stream_words", w, 3);
        repeat (4) @(posedge clk);
        #1;
        data_a = 9'd0;

        // Mid-word disturbance: data changes and en_write drops at cycle 10.
        @(negedge clk);
        data_a = 9'h1C3; en_a = 1'b1;
        @(posedge clk); #1;
        cyc = 0; cap = 8'd0; prev_sclk = sclk_a;
        while (cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 10) begin
                data_a = 9'h03C;
                en_a = 1'b0;
            end
            if (!prev_sclk && sclk_a) cap = {cap[6:0], mosi_a};
            prev_sclk = sclk_a;
            if (wr_done_a) break;
        end
        check("disturb_byte", int'(cap), 8'hC3);
        check("disturb_latency", cyc, 32);
        extra = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!cs_a || busy_a) extra++;
        end
        check("disturb_no_reaccept", extra, 0);
        $display("disturb: byte=%h lat=%0d extra=%0d", cap, cyc, extra);

        // Reset at cycle 12 of a word, with en_write still requesting.
        @(negedge clk);
        data_a = 9'h1F8; en_a = 1'b1;
        @(posedge clk); #1;
        wd_seen = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (wr_done_a) wd_seen++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_cs", int'(cs_a), 1);
        check("rst_mid_sclk", int'(sclk_a), 0);
        check("rst_mid_busy", int'(busy_a), 0);
        act_bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (!cs_a || sclk_a) act_bad++;
            if (wr_done_a) wd_seen++;
        end
        check("rst_hold_quiet", act_bad, 0);
        en_a = 1'b0;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (wr_done_a || !cs_a) wd_seen++;
        end
        check("rst_no_wr_done", wd_seen, 0);
        do_word(1'b0, 9'h1AA, cap, lat, cs_low, rises, dc_bad, mosi_bad);
        check("post_rst_byte", int'(cap), 8'hAA);
        check("post_rst_latency", lat, 32);
        check("post_rst_rises", rises, 8);
        $display("post-reset word: byte=%h lat=%0d", cap, lat);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lcd_spi_tx.md
LCD_SPI_TX -- requirements
Module: lcd_spi_tx

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 2, meaning SCLK half-period in clk_50MHz cycles (legal range 1..255).
REQ-002 SHALL provide port clk_50MHz  input  1  system clock; the block has one clock.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port data  input  9  word to send; bit 8 = D/C (1 data, 0 command), bits 7:0 = payload.
REQ-005 SHALL provide port en_write  input  1  write request, level-sensitive.
REQ-006 SHALL provide port sclk  output  1  SPI clock, mode 0 (idle low; LCD samples on rising edge).
REQ-007 SHALL provide port mosi  output  1  SPI serial data, MSB first.
REQ-008 SHALL provide port cs  output  1  chip select, active low.
REQ-009 SHALL provide port dc  output  1  data/command select, driven from the latched data[8].
REQ-010 SHALL provide port wr_done  output  1  one-cycle pulse marking word completion.
REQ-011 SHALL provide port busy  output  1  high whenever the state is not IDLE.
REQ-012 SHALL register all outputs, with no combinational path from inputs to outputs.

Function
REQ-013 SHALL implement states IDLE, SHIFT and DONE.
REQ-014 IDLE: when en_write=1 at a clock edge, SHALL latch data into a 9-bit shift register and set cs=0, dc=data[8], mosi=data[7], sclk=0, bit_cnt=7, div_cnt=0, and enter SHIFT.
REQ-015 IDLE with en_write=0: SHALL hold cs=1, sclk=0 and keep mosi/dc at their last values.
REQ-016 SHIFT: div_cnt SHALL count 0..CLK_DIV-1; at terminal count it SHALL wrap to 0 and toggle sclk.
REQ-017 Rising toggle (sclk 0->1): SHALL leave mosi unchanged.
REQ-018 Falling toggle (sclk 1->0) with bit_cnt>0: SHALL decrement bit_cnt and drive mosi with the next lower payload bit.
REQ-019 Falling toggle with bit_cnt=0: SHALL set sclk=0, cs=1, wr_done=1 and enter DONE.
REQ-020 DONE: SHALL lasts exactly one cycle, then clear wr_done and enter IDLE unconditionally; en_write SHALL NOT be sampled in DONE.
REQ-021 Latency: wr_done SHALL be high in cycle 16*CLK_DIV after the accepting edge (accept = cycle 0).
REQ-022 Throughput: with en_write held high, consecutive accepts SHALL be 16*CLK_DIV+2 cycles apart (34 at CLK_DIV=2); cs SHALL be high for 2 cycles between words.
REQ-023 Data source: the upstream may change data in the cycle after wr_done; the next word SHALL be taken from the IDLE-cycle value, never from the DONE-cycle value.
REQ-024 Mid-word input changes: changes to data or en_write during SHIFT SHALL be ignored; the latched word completes.
REQ-025 Pulse count: SHALL produce exactly 8 sclk rising edges per word, with mosi stable for at least CLK_DIV cycles before each rising edge and while sclk is high.
REQ-026 Counter widths: div_cnt SHALL be 8 bits and bit_cnt 3 bits; neither counter SHALL wrap outside the ranges above.
REQ-027 CLK_DIV=1: SHALL toggle sclk every cycle (25 MHz) with identical sequencing.

Reset
REQ-028 While rst=1 at a clock edge, SHALL set state=IDLE, sclk=0, mosi=0, cs=1, dc=0, wr_done=0, busy=0, div_cnt=0, bit_cnt=0 and clear the shift register.
REQ-029 Reset mid-word: SHALL abort the transfer with no wr_done pulse; the first accept SHALL occur no earlier than the first edge after rst falls.
REQ-030 SHALL drive no activity on sclk or cs while rst=1, regardless of en_write.

Verification
REQ-031 Single data word: CLK_DIV=2, data=9'h1F8, one en_write pulse -> cs low 32 cycles; dc=1; mosi bits 1,1,1,1,1,0,0,0 sampled on 8 rising edges; one wr_done pulse in cycle 32; busy low afterwards.
REQ-032 Command word: data=9'h036 -> dc=0 for the whole word; bits 0,0,1,1,0,1,1,0 captured.
REQ-033 Streaming: en_write held high, data alternating 9'h107/9'h1E0 and updated the cycle after each wr_done -> accepts 34 cycles apart; each word captured matches the value present in its IDLE cycle; 2-cycle cs-high gap between words.
REQ-034 Mid-word disturbance: change data and drop en_write at cycle 10 -> original word still sent completely; no second accept.
REQ-035 Reset mid-word: assert rst at cycle 12 -> next cycle cs=1, sclk=0, wr_done never pulses; after release a new word transfers normally.
REQ-036 CLK_DIV=1 sweep: data=9'h1A5 -> sclk period 2 cycles; wr_done in cycle 16; captured byte 8'hA5 with dc=1.
